// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Write-side front end of the multithreaded register-file bank. Single-cycle
//   ALU results and out-of-order load returns share one registered write port.
//   Load returns are queued in a small FIFO. A queued load is forced through
//   when the FIFO is full, or after it has lost to the ALU STARVE_LIMIT times.
//   An ALU write kills any older queued load to the same (thread, register),
//   so the stale load data can never land on top of the newer ALU result.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   alu_valid/ready/th_id/waddr/wdata   ALU result handshake and payload
//   ld_valid/ready/th_id/waddr/wdata    load-return handshake and payload
//   q_th_id, q_addr0, q_addr1  pending-load lookup from the issue stage
//   pend0, pend1               a live queued load targets the looked-up register
//   wena, w_th_id, waddr, wdata  registered register-file write port
//   ld_count                   occupied FIFO entries (live + killed)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 4,
   parameter int TH_ID_WIDTH  = 2,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           alu_valid,
   output logic                           alu_ready,
   input  logic [TH_ID_WIDTH-1:0]         alu_th_id,
   input  logic [ADDR_WIDTH-1:0]          alu_waddr,
   input  logic [DATA_WIDTH-1:0]          alu_wdata,
   input  logic                           ld_valid,
   output logic                           ld_ready,
   input  logic [TH_ID_WIDTH-1:0]         ld_th_id,
   input  logic [ADDR_WIDTH-1:0]          ld_waddr,
   input  logic [DATA_WIDTH-1:0]          ld_wdata,
   input  logic [TH_ID_WIDTH-1:0]         q_th_id,
   input  logic [ADDR_WIDTH-1:0]          q_addr0,
   input  logic [ADDR_WIDTH-1:0]          q_addr1,
   output logic                           pend0,
   output logic                           pend1,
   output logic                           wena,
   output logic [TH_ID_WIDTH-1:0]         w_th_id,
   output logic [ADDR_WIDTH-1:0]          waddr,
   output logic [DATA_WIDTH-1:0]          wdata,
   output logic [$clog2(FIFO_DEPTH):0]    ld_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

   // FIFO storage: live flags need reset, payload arrays do not
   logic [FIFO_DEPTH-1:0]  live_q;
   logic [TH_ID_WIDTH-1:0] th_q   [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]  addr_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]  data_q [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [AGE_W-1:0] age_q, age_d;

   logic                   wena_q;
   logic [TH_ID_WIDTH-1:0] w_th_id_q;
   logic [ADDR_WIDTH-1:0]  waddr_q;
   logic [DATA_WIDTH-1:0]  wdata_q;

   logic empty, full, head_live, head_killed, urgent;
   logic alu_fire, alu_kill, push, pop, wr_en, wr_sel_ld;
   logic [FIFO_DEPTH-1:0] kill_hit, match0, match1;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CNT_FULL);
   assign head_live   = !empty &&  live_q[rd_ptr_q];
   assign head_killed = !empty && !live_q[rd_ptr_q];
   assign urgent      = head_live && (full || age_q >= AGE_MAX);

   // Ready signals depend only on registered state, never on this cycle's pop
   assign ld_ready  = !reset && !full;
   assign alu_ready = !reset && !urgent;

   assign alu_fire = alu_valid && alu_ready;
   assign alu_kill = alu_fire && (alu_waddr != '0);
   // Loads to r0 are accepted and discarded
   assign push     = ld_valid && ld_ready && (ld_waddr != '0);

   // Popped entries get live cleared, so live implies occupied and the
   // lookup needs no occupancy mask.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      assign kill_hit[gi] = alu_kill && (th_q[gi] == alu_th_id) && (addr_q[gi] == alu_waddr);
      assign match0[gi]   = live_q[gi] && (th_q[gi] == q_th_id) && (addr_q[gi] == q_addr0);
      assign match1[gi]   = live_q[gi] && (th_q[gi] == q_th_id) && (addr_q[gi] == q_addr1);
   end

   assign pend0 = (q_addr0 != '0) && (|match0);
   assign pend1 = (q_addr1 != '0) && (|match1);

   // Grant: killed head drains for free, then starving/full head, then ALU,
   // then an uncontested live head.
   always_comb begin
      pop       = 1'b0;
      wr_en     = 1'b0;
      wr_sel_ld = 1'b0;
      if (head_killed) begin
         pop   = 1'b1;
         wr_en = alu_kill;
      end else if (urgent) begin
         pop       = 1'b1;
         wr_en     = 1'b1;
         wr_sel_ld = 1'b1;
      end else if (alu_fire) begin
         wr_en = alu_kill;
      end else if (head_live) begin
         pop       = 1'b1;
         wr_en     = 1'b1;
         wr_sel_ld = 1'b1;
      end
   end

   always_comb begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_comb begin
      age_d = age_q;
      if (pop || empty)
         age_d = '0;
      else if (head_live && (age_q < AGE_MAX))
         age_d = age_q + AGE_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         live_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         age_q    <= '0;
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            if (kill_hit[i]) live_q[i] <= 1'b0;
         if (pop) begin
            live_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q         <= rd_ptr_q + PTR_W'(1);
         end
         // Push comes last so a same-cycle ALU write cannot kill the new entry
         if (push) begin
            live_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         age_q   <= age_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         th_q[wr_ptr_q]   <= ld_th_id;
         addr_q[wr_ptr_q] <= ld_waddr;
         data_q[wr_ptr_q] <= ld_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wena_q    <= 1'b0;
         w_th_id_q <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         wena_q <= wr_en;
         if (wr_en) begin
            if (wr_sel_ld) begin
               w_th_id_q <= th_q[rd_ptr_q];
               waddr_q   <= addr_q[rd_ptr_q];
               wdata_q   <= data_q[rd_ptr_q];
            end else begin
               w_th_id_q <= alu_th_id;
               waddr_q   <= alu_waddr;
               wdata_q   <= alu_wdata;
            end
         end
      end
   end

   assign wena     = wena_q;
   assign w_th_id  = w_th_id_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign ld_count = count_q;

endmodule
